ecc_scalar_mul_ctrl: RTL
========================

ECC_SCALAR_MUL_CTRL -- requirements
Module: ecc_scalar_mul_ctrl

Interface
REQ-001 SHALL have parameter W, default 256, operand/coordinate width in bits.
REQ-002 SHALL have parameter IDXW, default $clog2(W), scalar bit-index width.
REQ-003 SHALL have i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_start  input  1  one-cycle request to compute k*P; sampled only in IDLE.
REQ-006 SHALL have i_k  input  W  scalar k; captured on accepted i_start.
REQ-007 SHALL have i_px, i_py  input  W each  base point P; captured on accepted i_start.
REQ-008 SHALL have o_busy  output  1  high from the cycle after acceptance until o_done.
REQ-009 SHALL have o_done  output  1  one-cycle pulse; o_rx/o_ry are valid and held until the next accepted i_start.
REQ-010 SHALL have o_rx, o_ry  output  W each  result k*P; point at infinity = all ones.
REQ-011 SHALL have o_op_start  output  1  one-cycle start pulse to the point-operation unit.
REQ-012 SHALL have o_op_dbl  output  1  1 = double (x1,y1), 0 = add (x1,y1)+(x2,y2); held stable while the op is outstanding.
REQ-013 SHALL have o_op_x1, o_op_y1, o_op_x2, o_op_y2  output  W each  operands, held stable while the op is outstanding.
REQ-014 SHALL have i_op_finish  input  1  one-cycle completion pulse from the point-operation unit.
REQ-015 SHALL have i_op_x, i_op_y  input  W each  operation result, valid with i_op_finish.

Function
REQ-016 SHALL implement left-to-right double-and-add: R=P at the highest set bit of k; for each lower bit i, descending: R=2R, then R=R+P if k[i]=1.
REQ-017 SHALL use states IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, NEXT, DONE.
REQ-018 IDLE->SCAN on i_start; k, P latched, o_busy rises next cycle.
REQ-019 SCAN (1 cycle): computes msb index m; k=0 -> DONE with R=all ones; m=0 -> DONE with R=P; otherwise idx=m-1 -> DBL.
REQ-020 DBL and ADD assert o_op_start for exactly one cycle, then move to DBL_WAIT or ADD_WAIT.
REQ-021 DBL_WAIT/ADD_WAIT wait indefinitely; on i_op_finish, latch the result: DBL_WAIT -> ADD (if an add is due) else NEXT; ADD_WAIT -> NEXT.
REQ-022 An i_op_finish that arrives outside a *_WAIT state SHALL be ignored.
REQ-023 NEXT: idx=0 -> DONE; otherwise idx decrements -> DBL.
REQ-024 DONE: drives R onto o_rx/o_ry, pulses o_done, clears o_busy -> IDLE, all in the same cycle.
REQ-025 i_start while busy SHALL be ignored and SHALL NOT disturb captured operands.
REQ-026 Exactly one point operation SHALL be outstanding at any time.

Reset
REQ-027 Reset SHALL force IDLE.
REQ-028 Reset SHALL clear o_busy, o_done and o_op_start to 0.
REQ-029 Reset SHALL clear o_rx/o_ry, all operand outputs and internal R to 0.
REQ-030 Reset asserted mid-operation SHALL abandon the computation; a late i_op_finish after reset release SHALL be ignored per REQ-022.

Configuration
REQ-031 Macro ECC_ADD_ALWAYS_EN defined: ADD SHALL be issued for every bit; the result is committed to R only when k[idx]=1, otherwise discarded (constant op sequence).
REQ-032 ECC_ADD_ALWAYS_EN undefined: ADD SHALL be issued only when k[idx]=1.

Structure
REQ-033 Package ecc_ctrl_pkg SHALL hold the state enum and the INF_COORD (all ones) constant.
REQ-034 Sub-module ecc_msb_find SHALL implement the combinational priority encoder that produces m and a zero flag.

Verification
Bench op-unit model: P=(n,0) stands for n; double -> (2*x1,0), add -> (x1+x2,0); finish 5 cycles after start.
REQ-035 k=13, P=(1,0), ADD_ALWAYS_EN undefined -> o_rx=13, o_ry=0; 3 doubles + 2 adds = 5 o_op_start pulses; exactly one o_done.
REQ-036 Same stimulus, ADD_ALWAYS_EN defined -> o_rx=13; 6 o_op_start pulses alternating dbl/add.
REQ-037 k=0 -> o_rx=o_ry=all ones, zero o_op_start pulses; k=1, P=(7,0) -> o_rx=7, zero ops.
REQ-038 i_start re-pulsed during k=13 run with k=5 -> ignored; result 13.
REQ-039 Reset asserted during the 2nd DBL_WAIT, then stray i_op_finish -> state IDLE, outputs 0, no o_done; next run k=6 -> o_rx=6.
REQ-040 k=2^(W-1), P=(1,0) under a modulo-free model -> W-1 doubles, no adds (undefined macro), o_done once.

Source files
------------

// File: rtl/ecc_ctrl_pkg.sv
// Shared types and constants for the ECC scalar-multiplication controller.
package ecc_ctrl_pkg;

    // Controller states, exposed on the debug output o_state.
    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DBL,
        DBL_WAIT,
        ADD,
        ADD_WAIT,
        NEXT,
        DONE
    } state_t;

    // Widest coordinate supported; users slice INF_COORD down to their W.
    localparam int MAX_W = 1024;

    // Point at infinity is encoded as all-ones coordinates.
    localparam logic [MAX_W-1:0] INF_COORD = '1;

endpackage

// File: rtl/ecc_msb_find.sv
// Combinational priority encoder: index of the highest set bit of k, plus a
// flag for k == 0 (in which case msb reads as 0).
module ecc_msb_find #(
    parameter int W    = 256,
    parameter int IDXW = $clog2(W)
) (
    input  logic [W-1:0]    k,
    output logic [IDXW-1:0] msb,
    output logic            zero
);

    // Scan upward so the last set bit seen, the highest one, wins.
    always_comb begin
        msb  = '0;
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (k[i]) begin
                msb  = i[IDXW-1:0];
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ecc_scalar_mul_ctrl.sv
// Left-to-right double-and-add controller for k*P. It sequences an external
// point-operation unit (one op in flight at a time) and returns R = k*P.
// Optional macro ECC_ADD_ALWAYS_EN: issue an ADD for every scalar bit and
// commit it only when the bit is set, giving a data-independent op sequence.
//
// Op handshake: o_op_start pulses for one cycle with o_op_dbl and the
// operands, which stay frozen until i_op_finish; i_op_x/i_op_y are taken only
// in the cycle i_op_finish is high and only while waiting for a result.
module ecc_scalar_mul_ctrl
    import ecc_ctrl_pkg::*;
#(
    parameter int W    = 256,
    parameter int IDXW = $clog2(W)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_k,
    input  logic [W-1:0] i_px,
    input  logic [W-1:0] i_py,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_rx,
    output logic [W-1:0] o_ry,
    output logic         o_op_start,
    output logic         o_op_dbl,
    output logic [W-1:0] o_op_x1,
    output logic [W-1:0] o_op_y1,
    output logic [W-1:0] o_op_x2,
    output logic [W-1:0] o_op_y2,
    input  logic         i_op_finish,
    input  logic [W-1:0] i_op_x,
    input  logic [W-1:0] i_op_y,
    output state_t       o_state
);

    localparam logic [W-1:0]    INF     = INF_COORD[W-1:0];
    localparam logic [IDXW-1:0] IDX_ONE = 1;

    state_t          state;
    logic [W-1:0]    k_q;
    logic [W-1:0]    px_q;
    logic [W-1:0]    py_q;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] msb;
    logic            k_zero;
    logic            bit_set;
    logic            add_due;
    logic            add_commit;

    ecc_msb_find #(.W(W), .IDXW(IDXW)) u_msb_find (
        .k    (k_q),
        .msb  (msb),
        .zero (k_zero)
    );

    assign bit_set = k_q[idx];
    assign o_state = state;

`ifdef ECC_ADD_ALWAYS_EN
    assign add_due    = 1'b1;
    assign add_commit = bit_set;
`else
    assign add_due    = bit_set;
    assign add_commit = 1'b1;
`endif

    // Main sequencer: capture request, walk scalar bits MSB-1 down to 0.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            k_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rx       <= '0;
            o_ry       <= '0;
            o_op_start <= 1'b0;
            o_op_dbl   <= 1'b0;
            o_op_x1    <= '0;
            o_op_y1    <= '0;
            o_op_x2    <= '0;
            o_op_y2    <= '0;
        end else begin
            o_op_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        k_q    <= i_k;
                        px_q   <= i_px;
                        py_q   <= i_py;
                        o_busy <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (k_zero) begin
                        r_x   <= INF;
                        r_y   <= INF;
                        state <= DONE;
                    end else begin
                        r_x <= px_q;
                        r_y <= py_q;
                        if (msb == '0) begin
                            state <= DONE;
                        end else begin
                            idx   <= msb - IDX_ONE;
                            state <= DBL;
                        end
                    end
                end
                DBL: begin
                    o_op_start <= 1'b1;
                    o_op_dbl   <= 1'b1;
                    o_op_x1    <= r_x;
                    o_op_y1    <= r_y;
                    state      <= DBL_WAIT;
                end
                DBL_WAIT: begin
                    if (i_op_finish) begin
                        r_x   <= i_op_x;
                        r_y   <= i_op_y;
                        state <= add_due ? ADD : NEXT;
                    end
                end
                ADD: begin
                    o_op_start <= 1'b1;
                    o_op_dbl   <= 1'b0;
                    o_op_x1    <= r_x;
                    o_op_y1    <= r_y;
                    o_op_x2    <= px_q;
                    o_op_y2    <= py_q;
                    state      <= ADD_WAIT;
                end
                ADD_WAIT: begin
                    if (i_op_finish) begin
                        if (add_commit) begin
                            r_x <= i_op_x;
                            r_y <= i_op_y;
                        end
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx - IDX_ONE;
                        state <= DBL;
                    end
                end
                DONE: begin
                    o_rx   <= r_x;
                    o_ry   <= r_y;
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
